// File: rtl/riscv_wb_arbiter_if.sv
// Write-back bus bundle: ALU/LSU write requests, issue-stage hazard query,
// and the register-file write port with the busy scoreboard.
interface riscv_wb_arbiter_if #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_REGISTER = 32
);
  localparam int unsigned SEL_WIDTH = 5;

  logic                    alu_valid;
  logic [SEL_WIDTH-1:0]    alu_addr;
  logic [DATA_WIDTH-1:0]   alu_data;
  logic                    alu_ready;
  logic                    lsu_valid;
  logic [SEL_WIDTH-1:0]    lsu_addr;
  logic [DATA_WIDTH-1:0]   lsu_data;
  logic                    lsu_ready;
  logic                    iss_valid;
  logic [SEL_WIDTH-1:0]    iss_rd;
  logic [SEL_WIDTH-1:0]    iss_rs1;
  logic [SEL_WIDTH-1:0]    iss_rs2;
  logic                    stall;
  logic                    reg_wen;
  logic [SEL_WIDTH-1:0]    addr_d;
  logic [DATA_WIDTH-1:0]   data_d;
  logic [NUM_REGISTER-1:0] busy_vec;

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  lsu_valid, lsu_addr, lsu_data,
    input  iss_valid, iss_rd, iss_rs1, iss_rs2,
    output alu_ready, lsu_ready, stall,
    output reg_wen, addr_d, data_d, busy_vec
  );

  modport master (
    output alu_valid, alu_addr, alu_data,
    output lsu_valid, lsu_addr, lsu_data,
    output iss_valid, iss_rd, iss_rs1, iss_rs2,
    input  alu_ready, lsu_ready, stall,
    input  reg_wen, addr_d, data_d, busy_vec
  );
endinterface

// File: rtl/riscv_wb_arbiter.sv
// Round-robin ALU/LSU arbitration onto the single register-file write port,
// plus a busy scoreboard that stalls issue on RAW/WAW hazards.
module riscv_wb_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_REGISTER = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  riscv_wb_arbiter_if.slave     bus
);
  localparam int unsigned SEL_WIDTH = 5;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LSU = 1'b1
  } grant_e;

  grant_e                  last_grant_q, last_grant_d;
  logic                    reg_wen_q, reg_wen_d;
  logic [SEL_WIDTH-1:0]    waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [NUM_REGISTER-1:0] busy_q, busy_d;

  logic                    alu_gnt_c, lsu_gnt_c, gnt_c;
  logic [SEL_WIDTH-1:0]    gnt_addr_c;
  logic [DATA_WIDTH-1:0]   gnt_data_c;
  logic [NUM_REGISTER-1:0] busy_view_c;
  logic                    stall_c, issue_c;

  // Arbitration: a lone requester wins; under contention the side that did not win last time.
  always_comb begin
    alu_gnt_c = 1'b0;
    lsu_gnt_c = 1'b0;
    if (!reset) begin
      if (bus.alu_valid && bus.lsu_valid) begin
        alu_gnt_c = (last_grant_q == GNT_LSU);
        lsu_gnt_c = (last_grant_q == GNT_ALU);
      end else begin
        alu_gnt_c = bus.alu_valid;
        lsu_gnt_c = bus.lsu_valid;
      end
    end
  end

  assign gnt_c      = alu_gnt_c | lsu_gnt_c;
  assign gnt_addr_c = alu_gnt_c ? bus.alu_addr : bus.lsu_addr;
  assign gnt_data_c = alu_gnt_c ? bus.alu_data : bus.lsu_data;

  // Hazard check uses only current busy bits; x0 is never considered busy.
  assign busy_view_c = {busy_q[NUM_REGISTER-1:1], 1'b0};
  assign stall_c     = reset |
                       (bus.iss_valid & (busy_view_c[bus.iss_rs1] |
                                         busy_view_c[bus.iss_rs2] |
                                         busy_view_c[bus.iss_rd]));
  assign issue_c     = bus.iss_valid & ~stall_c;

  always_comb begin
    last_grant_d = last_grant_q;
    reg_wen_d    = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    busy_d       = busy_q;

    if (gnt_c) begin
      last_grant_d = alu_gnt_c ? GNT_ALU : GNT_LSU;
      reg_wen_d    = (gnt_addr_c != SEL_WIDTH'(0));
      waddr_d      = gnt_addr_c;
      wdata_d      = gnt_data_c;
      busy_d[gnt_addr_c] = 1'b0;
    end

    // Set after clear so a new producer keeps ownership of the register.
    if (issue_c) begin
      busy_d[bus.iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= GNT_LSU;
      reg_wen_q    <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      busy_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      reg_wen_q    <= reg_wen_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.alu_ready = alu_gnt_c;
  assign bus.lsu_ready = lsu_gnt_c;
  assign bus.stall     = stall_c;
  assign bus.reg_wen   = reg_wen_q;
  assign bus.addr_d    = waddr_q;
  assign bus.data_d    = wdata_q;
  assign bus.busy_vec  = busy_q;

endmodule

// File: doc/riscv_wb_arbiter.md
Name: riscv_wb_arbiter

Overview:
Write-back controller for the 32-entry RISC-V register file, which has a single write port.
- Shares that write port between the ALU result path and the load/store unit (LSU) load-return path using round-robin arbitration.
- Keeps a busy scoreboard of registers with an outstanding write and raises a stall to issue logic on RAW and WAW hazards.
- Drives the register file signals reg_wen, addr_d and data_d from registers.

Parameters:
DATA_WIDTH, 32, width of write data
NUM_REGISTER, 32, number of architectural registers; x0 is hardwired zero
SEL_WIDTH, 5, register address width; localparam, fixed

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
alu_valid  in  1  ALU write-back request
alu_addr  in  SEL_WIDTH  ALU destination register
alu_data  in  DATA_WIDTH  ALU result
alu_ready  out  1  ALU request accepted this cycle (combinational)
lsu_valid  in  1  LSU load-return request
lsu_addr  in  SEL_WIDTH  LSU destination register
lsu_data  in  DATA_WIDTH  load data
lsu_ready  out  1  LSU request accepted this cycle (combinational)
iss_valid  in  1  issue stage presenting an instruction
iss_rd  in  SEL_WIDTH  destination of the issuing instruction
iss_rs1  in  SEL_WIDTH  source 1 of the issuing instruction
iss_rs2  in  SEL_WIDTH  source 2 of the issuing instruction
stall  out  1  issue blocked (combinational)
reg_wen  out  1  register file write enable (registered)
addr_d  out  SEL_WIDTH  register file write address (registered)
data_d  out  DATA_WIDTH  register file write data (registered)
busy_vec  out  NUM_REGISTER  scoreboard, bit n = 1 means a write to xn is pending

Behaviour:
Reset (synchronous, reset=1 at the clock edge):
- busy_vec=0, reg_wen=0, addr_d=0, data_d=0.
- last_grant=LSU, so the ALU wins the first conflict.
- A write captured in the output register is dropped. reg_wen is 0 in the cycle after reset, and the register file must not see that write.
- While reset=1: alu_ready=0, lsu_ready=0, stall=1.

Arbitration (combinational):
- Only alu_valid: alu_ready=1.
- Only lsu_valid: lsu_ready=1.
- Both valid: grant the requester that is not last_grant; the other sees ready=0.
- A requester holds valid, addr and data stable until it sees ready.
- last_grant updates only on the edge where a grant is taken.
- Two-requester round-robin: neither side waits more than 1 cycle under continuous contention.

Write port:
- Latency is 1 cycle. On the grant edge: reg_wen<=1, addr_d<=granted addr, data_d<=granted data.
- No grant: reg_wen<=0; addr_d and data_d hold their values.
- A grant with addr==0 is accepted (ready=1) but produces reg_wen<=0. This is the x0 discard.
- Back-to-back grants give one write per cycle with no bubble.

Scoreboard:
- Stall condition: stall = iss_valid & (busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd]). busy[0] reads as 0.
- Stall uses current busy bits only. A clear on the same edge is not forwarded, which keeps the check conservative.
- Issue accepted (iss_valid & !stall & !reset): busy[iss_rd]<=1, unless iss_rd==0.
- Grant to register n: busy[n]<=0 on that edge.
- Set and clear of the same register on the same edge: set wins, because the new producer owns the register.
- A write to a register that is not busy is legal. The bit stays 0 and no error is flagged.
- busy_vec is a direct register output.

Simultaneous events:
- ALU and LSU granted in the same cycle cannot occur; at most one grant per cycle.
- Issue set, write-back clear and arbitration are all evaluated in the same cycle and are independent apart from the set-wins rule.

Test Plan:
- Reset then idle:
  - Drive reset=1 for 2 cycles, then release with all inputs 0.
  - Required: reg_wen=0, addr_d=0, data_d=0, busy_vec=0, stall=0.
- Single ALU write:
  - alu_valid=1, alu_addr=5, alu_data=0xDEADBEEF for 1 cycle.
  - Required: alu_ready=1 that cycle; next cycle reg_wen=1, addr_d=5, data_d=0xDEADBEEF; the cycle after, reg_wen=0.
- Contention round-robin:
  - Hold alu_valid and lsu_valid (addr 3 and 4) for 4 cycles, with each side presenting new data after every accept.
  - Required: grants alternate ALU, LSU, ALU, LSU; write port shows addr 3, 4, 3, 4 on consecutive cycles.
- Hazard stall:
  - Issue rd=7 (accepted; busy_vec bit 7=1). Next, issue rs1=7.
  - Required: stall=1 until the LSU write to x7 is granted; stall=0 the cycle after the grant; bit 7 cleared.
  - Also required: iss_rd=7 while busy stalls (WAW); rs1=0 never stalls.
- x0 discard:
  - lsu_valid with lsu_addr=0, lsu_data=0x12345678.
  - Required: lsu_ready=1, reg_wen stays 0, busy_vec unchanged.
- Reset mid-operation:
  - Grant an ALU write to x9 (busy bit 9 set by an earlier issue), then assert reset on the next edge.
  - Required: reg_wen=0 the cycle after reset, busy_vec=0, and the next contention is won by the ALU.
